// File: rtl/lsu_resp_pkg.sv
// Shared types and limits for the lsu_resp load/store responder.
// Entry layout and FSM state encoding are common to the top and its FIFO.
package lsu_resp_pkg;
    localparam int LAT_MAX   = 4;
    localparam int DEPTH_MAX = 4;
    localparam int CD_W      = 2;

    typedef enum logic {
        IDLE,
        WAIT
    } gnt_state_e;

    typedef struct packed {
        logic            we;
        logic            err;
        logic [31:0]     rdata;
        logic [CD_W-1:0] countdown;
    } resp_entry_t;

    localparam int ENTRY_W = $bits(resp_entry_t);
endpackage

// File: rtl/lsu_resp_fifo.sv
// In-order queue of outstanding responses; every stored countdown ticks toward 0
// each cycle, and the head is popped by the parent once its countdown reaches 0.
module lsu_resp_fifo
    import lsu_resp_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               push_i,
    input  logic [ENTRY_W-1:0] push_entry_i,
    input  logic               pop_i,
    output logic [ENTRY_W-1:0] head_o,
    output logic               full_o,
    output logic               empty_o
);
    localparam int CNT_W = 3;

    resp_entry_t      ent_q [DEPTH];
    resp_entry_t      ent_d [DEPTH];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        ent_d = ent_q;
        cnt_d = cnt_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_d[i].countdown != '0) begin
                ent_d[i].countdown = ent_d[i].countdown - 1'b1;
            end
        end
        if (pop_i && cnt_q != '0) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                ent_d[i] = ent_d[i + 1];
            end
            cnt_d = cnt_d - 1'b1;
        end
        // Pushed entry lands after the shift so it keeps its full countdown.
        if (push_i && cnt_d != CNT_W'(DEPTH)) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (cnt_d == CNT_W'(i)) begin
                    ent_d[i] = resp_entry_t'(push_entry_i);
                end
            end
            cnt_d = cnt_d + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        ent_q <= ent_d;
    end

    assign head_o  = ent_q[0];
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
endmodule

// File: rtl/lsu_resp.sv
// Load/store responder: grant FSM with optional delay, byte-enabled word memory,
// fixed-latency in-order responses. Define LSU_RESP_ERR_EN to flag out-of-range addresses.
module lsu_resp
    import lsu_resp_pkg::*;
#(
    parameter int MEM_WORDS = 64,
    parameter int LATENCY   = 1,
    parameter int DEPTH     = 2,
    parameter int GNT_DELAY = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        busy_o
);
    localparam int              AW       = $clog2(MEM_WORDS);
    localparam logic [1:0]      DLY_LAST = 2'((GNT_DELAY > 0) ? GNT_DELAY - 1 : 0);
    localparam logic [CD_W-1:0] CD_INIT  = CD_W'(LATENCY - 1);

    if (LATENCY < 1 || LATENCY > LAT_MAX) begin : g_bad_latency
        $error("lsu_resp: LATENCY must be within 1..%0d", LAT_MAX);
    end
    if (DEPTH < 1 || DEPTH > DEPTH_MAX) begin : g_bad_depth
        $error("lsu_resp: DEPTH must be within 1..%0d", DEPTH_MAX);
    end
    if (GNT_DELAY < 0 || GNT_DELAY > 3) begin : g_bad_gnt_delay
        $error("lsu_resp: GNT_DELAY must be within 0..3");
    end
    if (MEM_WORDS < 2 || MEM_WORDS > (1 << 20) || (MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : g_bad_mem
        $error("lsu_resp: MEM_WORDS must be a power of two in 2..2^20");
    end

    gnt_state_e         state_q;
    gnt_state_e         state_d;
    logic [1:0]         dcnt_q;
    logic [1:0]         dcnt_d;
    logic [31:0]        mem_q [MEM_WORDS];
    logic [31:0]        mem_d [MEM_WORDS];
    logic               gnt_raw;
    logic               gnt;
    logic               oor;
    logic [AW-1:0]      idx;
    logic               fifo_full;
    logic               fifo_empty;
    logic               rvalid;
    resp_entry_t        push_entry;
    resp_entry_t        head;
    logic [ENTRY_W-1:0] head_bits;
    logic               unused_sig;

    assign idx = data_addr_i[2 +: AW];

`ifdef LSU_RESP_ERR_EN
    assign oor        = (data_addr_i[31:2] >= 30'(MEM_WORDS));
    assign data_err_o = rvalid & head.err;
    assign unused_sig = ^data_addr_i;
`else
    assign oor        = 1'b0;
    assign data_err_o = 1'b0;
    assign unused_sig = ^{data_addr_i, head.err};
`endif

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        gnt_raw = 1'b0;
        case (state_q)
            IDLE: begin
                if (data_req_i && !fifo_full) begin
                    if (GNT_DELAY == 0) begin
                        gnt_raw = 1'b1;
                    end else begin
                        state_d = WAIT;
                        dcnt_d  = '0;
                    end
                end
            end
            WAIT: begin
                if (!data_req_i) begin
                    state_d = IDLE;
                    dcnt_d  = '0;
                end else if (dcnt_q == DLY_LAST) begin
                    // Delay expired: hold here until the queue has room.
                    if (!fifo_full) begin
                        gnt_raw = 1'b1;
                        state_d = IDLE;
                        dcnt_d  = '0;
                    end
                end else begin
                    dcnt_d = dcnt_q + 2'd1;
                end
            end
            default: begin
                state_d = IDLE;
                dcnt_d  = '0;
            end
        endcase
    end

    // Combinational grant must stay low while reset is held.
    assign gnt = gnt_raw & rst_ni;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (gnt && data_we_i && !oor) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be_i[b]) begin
                    mem_d[idx][8*b +: 8] = data_wdata_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        push_entry           = '0;
        push_entry.we        = data_we_i;
        push_entry.err       = oor;
        push_entry.rdata     = (data_we_i || oor) ? 32'h0 : mem_q[idx];
        push_entry.countdown = CD_INIT;
    end

    lsu_resp_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_i       (gnt & data_req_i),
        .push_entry_i (push_entry),
        .pop_i        (rvalid),
        .head_o       (head_bits),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty)
    );

    assign head          = resp_entry_t'(head_bits);
    assign rvalid        = !fifo_empty && (head.countdown == '0);
    assign data_gnt_o    = gnt;
    assign data_rvalid_o = rvalid;
    assign data_rdata_o  = (rvalid && !head.we) ? head.rdata : 32'h0;
    assign busy_o        = !fifo_empty || (state_q == WAIT);
endmodule
